// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vending_pkg
// Description : Shared types and constants for the 3x3 vending controller:
//               item indices, coin values, price table, credit/change limits,
//               plus helpers for price lookup and saturating change updates.
// Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    typedef enum logic [3:0] {
        ITEM_A1   = 4'd0,
        ITEM_A2   = 4'd1,
        ITEM_A3   = 4'd2,
        ITEM_B1   = 4'd3,
        ITEM_B2   = 4'd4,
        ITEM_B3   = 4'd5,
        ITEM_C1   = 4'd6,
        ITEM_C2   = 4'd7,
        ITEM_C3   = 4'd8,
        ITEM_NONE = 4'd15
    } item_e;

    localparam int NUM_ITEMS = 9;
    localparam int NUM_COINS = 6;

    // Coin values in cents
    localparam logic [8:0] COIN_NICKEL  = 9'd5;
    localparam logic [8:0] COIN_DIME    = 9'd10;
    localparam logic [8:0] COIN_QUARTER = 9'd25;
    localparam logic [8:0] COIN_FIFTY   = 9'd50;
    localparam logic [8:0] COIN_DOLLAR  = 9'd100;
    localparam logic [8:0] COIN_FIVE    = 9'd500;

    localparam logic [2:0]  INIT_STOCK = 3'd5;
    localparam logic [11:0] CREDIT_MAX = 12'd2000;
    localparam logic [13:0] CHANGE_MAX = 14'd9995;

    // Price in cents for an item index; 0 for anything outside A1..C3
    function automatic logic [8:0] item_price(input logic [3:0] idx);
        logic [8:0] price;
        case (idx)
            4'd0:    price = 9'd100;
            4'd1:    price = 9'd125;
            4'd2:    price = 9'd150;
            4'd3:    price = 9'd175;
            4'd4:    price = 9'd200;
            4'd5:    price = 9'd225;
            4'd6:    price = 9'd250;
            4'd7:    price = 9'd275;
            4'd8:    price = 9'd300;
            default: price = 9'd0;
        endcase
        return price;
    endfunction

    // Adds to the change register, clamping at the largest value the
    // 4-digit display can show in 5-cent steps
    function automatic logic [13:0] change_add(input logic [13:0] base,
                                               input logic [13:0] add);
        logic [14:0] sum;
        sum = {1'b0, base} + {1'b0, add};
        if (sum > {1'b0, CHANGE_MAX}) begin
            return CHANGE_MAX;
        end
        return sum[13:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd
// Description : Combinational 14-bit binary to 4-digit packed BCD converter
//               (double-dabble). Inputs above 9999 are not expected.
//   bin_i       in   14-bit binary value
//   bcd_o       out  4 BCD digits, [15:12] thousands .. [3:0] units
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd (
    input  logic [13:0] bin_i,
    output logic [15:0] bcd_o
);

    // [29:14] BCD accumulator, [13:0] binary shifted in from the top
    logic [29:0] w_scratch;

    always_comb begin
        w_scratch = {16'd0, bin_i};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (w_scratch[14 + 4*d +: 4] >= 4'd5) begin
                    w_scratch[14 + 4*d +: 4] = w_scratch[14 + 4*d +: 4] + 4'd3;
                end
            end
            w_scratch = {w_scratch[28:0], 1'b0};
        end
    end

    assign bcd_o = w_scratch[29:14];

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Two-flop synchroniser, optional debounce filter and
//               rising-edge detector for one level-sensitive button.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   btn_i       in   raw asynchronous button level
//   pulse_o     out  one-cycle pulse on each accepted rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic w_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= w_stable;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign w_stable = sync2_q;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] cnt_q;
            logic          stable_q;

            // The synced level must differ from the accepted level for
            // DEBOUNCE_CYCLES consecutive cycles before it is accepted;
            // any bounce back restarts the count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (sync2_q == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q    <= '0;
                    stable_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign w_stable = stable_q;
        end
    endgenerate

    assign pulse_o = w_stable & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/vending_machine_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_ctrl
// Description : 3x3 snack vending machine controller. Conditions all buttons,
//               tracks credit, change, pending selection and per-item stock,
//               and drives item LEDs plus a packed-BCD display word.
//   clk, reset                  clock, synchronous active-high reset
//   A1..C3                      item-select buttons (level)
//   nickel..five                coin/bill inputs (level)
//   cancelReset                 refund credit into change, drop selection
//   coinsDisp                   toggle credit/change view
//   gLEDxy / rLEDxy             item purchasable / item sold out
//   board7SD                    [31:16] pending price, [15:0] credit/change
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_ctrl
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        A1,
    input  logic        A2,
    input  logic        A3,
    input  logic        B1,
    input  logic        B2,
    input  logic        B3,
    input  logic        C1,
    input  logic        C2,
    input  logic        C3,
    input  logic        nickel,
    input  logic        dime,
    input  logic        quarter,
    input  logic        fifty,
    input  logic        dollar,
    input  logic        five,
    input  logic        cancelReset,
    input  logic        coinsDisp,
    output logic        gLEDA1,
    output logic        gLEDA2,
    output logic        gLEDA3,
    output logic        gLEDB1,
    output logic        gLEDB2,
    output logic        gLEDB3,
    output logic        gLEDC1,
    output logic        gLEDC2,
    output logic        gLEDC3,
    output logic        rLEDA1,
    output logic        rLEDA2,
    output logic        rLEDA3,
    output logic        rLEDB1,
    output logic        rLEDB2,
    output logic        rLEDB3,
    output logic        rLEDC1,
    output logic        rLEDC2,
    output logic        rLEDC3,
    output logic [31:0] board7SD
);

    localparam int NUM_BTNS = NUM_ITEMS + NUM_COINS + 2;

    // ------------------------------------------------------------------
    // Button conditioning: [8:0] items A1..C3, [14:9] coins nickel..five,
    // [15] cancelReset, [16] coinsDisp
    // ------------------------------------------------------------------
    logic [NUM_BTNS-1:0] w_btn_raw;
    logic [NUM_BTNS-1:0] w_pulse;

    assign w_btn_raw = {coinsDisp, cancelReset,
                        five, dollar, fifty, quarter, dime, nickel,
                        C3, C2, C1, B3, B2, B1, A3, A2, A1};

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_cond
            button_conditioner #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk     (clk),
                .rst     (reset),
                .btn_i   (w_btn_raw[gi]),
                .pulse_o (w_pulse[gi])
            );
        end
    endgenerate

    logic [NUM_ITEMS-1:0] w_item_pulse;
    logic [NUM_COINS-1:0] w_coin_pulse;
    logic                 w_cancel_pulse;
    logic                 w_disp_pulse;

    assign w_item_pulse   = w_pulse[NUM_ITEMS-1:0];
    assign w_coin_pulse   = w_pulse[NUM_ITEMS +: NUM_COINS];
    assign w_cancel_pulse = w_pulse[NUM_ITEMS + NUM_COINS];
    assign w_disp_pulse   = w_pulse[NUM_ITEMS + NUM_COINS + 1];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [11:0]                credit_q, credit_d;
    logic [13:0]                change_q, change_d;
    logic [3:0]                 sel_q, sel_d;
    logic                       view_q, view_d;
    logic [NUM_ITEMS-1:0][2:0]  stock_q, stock_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
            change_q <= '0;
            sel_q    <= ITEM_NONE;
            view_q   <= 1'b0;
            stock_q  <= {NUM_ITEMS{INIT_STOCK}};
        end else begin
            credit_q <= credit_d;
            change_q <= change_d;
            sel_q    <= sel_d;
            view_q   <= view_d;
            stock_q  <= stock_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse decoding
    // ------------------------------------------------------------------
    logic [8:0] w_coin_val;
    logic       w_coin_any;
    logic [3:0] w_item_idx;
    logic       w_item_any;

    // Only the highest-value coin is taken when several arrive together
    always_comb begin
        w_coin_val = 9'd0;
        if      (w_coin_pulse[5]) w_coin_val = COIN_FIVE;
        else if (w_coin_pulse[4]) w_coin_val = COIN_DOLLAR;
        else if (w_coin_pulse[3]) w_coin_val = COIN_FIFTY;
        else if (w_coin_pulse[2]) w_coin_val = COIN_QUARTER;
        else if (w_coin_pulse[1]) w_coin_val = COIN_DIME;
        else if (w_coin_pulse[0]) w_coin_val = COIN_NICKEL;
    end

    assign w_coin_any = |w_coin_pulse;
    assign w_item_any = |w_item_pulse;

    // Lowest index wins: scanning downward lets A1 overwrite the rest
    always_comb begin
        w_item_idx = ITEM_NONE;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (w_item_pulse[i]) begin
                w_item_idx = 4'(i);
            end
        end
    end

    logic w_sel_in_stock;
    logic w_item_in_stock;

    // Explicit compare loops avoid indexing stock with the out-of-range
    // ITEM_NONE code
    always_comb begin
        w_sel_in_stock  = 1'b0;
        w_item_in_stock = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if ((sel_q == 4'(i)) && (stock_q[i] != 3'd0)) begin
                w_sel_in_stock = 1'b1;
            end
            if ((w_item_idx == 4'(i)) && (stock_q[i] != 3'd0)) begin
                w_item_in_stock = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction logic: cancel > coin > item select > display toggle
    // ------------------------------------------------------------------
    logic [12:0] w_coin_sum;
    logic        w_vend;
    logic [3:0]  w_vend_idx;
    logic [12:0] w_vend_credit;

    assign w_coin_sum = {1'b0, credit_q} + {4'd0, w_coin_val};

    always_comb begin
        credit_d      = credit_q;
        change_d      = change_q;
        sel_d         = sel_q;
        view_d        = view_q;
        stock_d       = stock_q;
        w_vend        = 1'b0;
        w_vend_idx    = sel_q;
        w_vend_credit = {1'b0, credit_q};

        if (w_cancel_pulse) begin
            change_d = change_add(change_q, {2'd0, credit_q});
            credit_d = '0;
            sel_d    = ITEM_NONE;
        end else if (w_coin_any) begin
            if (w_coin_sum <= {1'b0, CREDIT_MAX}) begin
                // A coin that covers a pending selection vends immediately
                if (w_sel_in_stock && (w_coin_sum >= {4'd0, item_price(sel_q)})) begin
                    w_vend        = 1'b1;
                    w_vend_idx    = sel_q;
                    w_vend_credit = w_coin_sum;
                end else begin
                    credit_d = w_coin_sum[11:0];
                end
            end else begin
                // Over-limit coin goes straight back out as change
                change_d = change_add(change_q, {5'd0, w_coin_val});
            end
        end else if (w_item_any) begin
            if (w_item_in_stock) begin
                if (credit_q >= {3'd0, item_price(w_item_idx)}) begin
                    w_vend     = 1'b1;
                    w_vend_idx = w_item_idx;
                end else begin
                    sel_d = w_item_idx;
                end
            end
        end else if (w_disp_pulse) begin
            view_d = ~view_q;
            // Leaving the change view means the customer took the coins
            if (view_q) begin
                change_d = '0;
            end
        end

        if (w_vend) begin
            credit_d = '0;
            sel_d    = ITEM_NONE;
            change_d = change_add(change_q,
                                  14'(w_vend_credit - {4'd0, item_price(w_vend_idx)}));
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (w_vend_idx == 4'(i)) begin
                    stock_d[i] = stock_q[i] - 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // LEDs
    // ------------------------------------------------------------------
    logic [NUM_ITEMS-1:0] w_green;
    logic [NUM_ITEMS-1:0] w_red;

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_led
            assign w_green[gi] = (stock_q[gi] != 3'd0) &&
                                 (credit_q >= {3'd0, item_price(4'(gi))});
            assign w_red[gi]   = (stock_q[gi] == 3'd0);
        end
    endgenerate

    assign {gLEDC3, gLEDC2, gLEDC1, gLEDB3, gLEDB2, gLEDB1, gLEDA3, gLEDA2, gLEDA1} = w_green;
    assign {rLEDC3, rLEDC2, rLEDC1, rLEDB3, rLEDB2, rLEDB1, rLEDA3, rLEDA2, rLEDA1} = w_red;

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    logic [13:0] w_price_bin;
    logic [13:0] w_amount_bin;
    logic [15:0] w_price_bcd;
    logic [15:0] w_amount_bcd;

    assign w_price_bin  = (sel_q == ITEM_NONE) ? 14'd0 : {5'd0, item_price(sel_q)};
    assign w_amount_bin = view_q ? change_q : {2'd0, credit_q};

    bin2bcd u_bcd_price (
        .bin_i (w_price_bin),
        .bcd_o (w_price_bcd)
    );

    bin2bcd u_bcd_amount (
        .bin_i (w_amount_bin),
        .bcd_o (w_amount_bcd)
    );

    assign board7SD = {w_price_bcd, w_amount_bcd};

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_machine_ctrl
// Description : Directed self-checking bench for vending_machine_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_ctrl;

    localparam logic [8:0] M_A1 = 9'b000000001;
    localparam logic [8:0] M_A2 = 9'b000000010;
    localparam logic [8:0] M_B1 = 9'b000001000;
    localparam logic [8:0] M_C2 = 9'b010000000;
    localparam logic [8:0] M_C3 = 9'b100000000;

    localparam logic [5:0] K_NICKEL  = 6'b000001;
    localparam logic [5:0] K_DIME    = 6'b000010;
    localparam logic [5:0] K_QUARTER = 6'b000100;
    localparam logic [5:0] K_DOLLAR  = 6'b010000;
    localparam logic [5:0] K_FIVE    = 6'b100000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic A1 = 0, A2 = 0, A3 = 0, B1 = 0, B2 = 0, B3 = 0, C1 = 0, C2 = 0, C3 = 0;
    logic nickel = 0, dime = 0, quarter = 0, fifty = 0, dollar = 0, five = 0;
    logic cancelReset = 0, coinsDisp = 0;
    logic gLEDA1, gLEDA2, gLEDA3, gLEDB1, gLEDB2, gLEDB3, gLEDC1, gLEDC2, gLEDC3;
    logic rLEDA1, rLEDA2, rLEDA3, rLEDB1, rLEDB2, rLEDB3, rLEDC1, rLEDC2, rLEDC3;
    logic [31:0] board7SD;

    int vec_count = 0;
    int err_count = 0;

    logic [8:0] g;
    logic [8:0] r;
    assign g = {gLEDC3, gLEDC2, gLEDC1, gLEDB3, gLEDB2, gLEDB1, gLEDA3, gLEDA2, gLEDA1};
    assign r = {rLEDC3, rLEDC2, rLEDC1, rLEDB3, rLEDB2, rLEDB1, rLEDA3, rLEDA2, rLEDA1};

    always #5 clk = ~clk;

    vending_machine_ctrl #(.DEBOUNCE_CYCLES(0)) dut (
        .clk(clk), .reset(reset),
        .A1(A1), .A2(A2), .A3(A3), .B1(B1), .B2(B2), .B3(B3), .C1(C1), .C2(C2), .C3(C3),
        .nickel(nickel), .dime(dime), .quarter(quarter), .fifty(fifty),
        .dollar(dollar), .five(five),
        .cancelReset(cancelReset), .coinsDisp(coinsDisp),
        .gLEDA1(gLEDA1), .gLEDA2(gLEDA2), .gLEDA3(gLEDA3),
        .gLEDB1(gLEDB1), .gLEDB2(gLEDB2), .gLEDB3(gLEDB3),
        .gLEDC1(gLEDC1), .gLEDC2(gLEDC2), .gLEDC3(gLEDC3),
        .rLEDA1(rLEDA1), .rLEDA2(rLEDA2), .rLEDA3(rLEDA3),
        .rLEDB1(rLEDB1), .rLEDB2(rLEDB2), .rLEDB3(rLEDB3),
        .rLEDC1(rLEDC1), .rLEDC2(rLEDC2), .rLEDC3(rLEDC3),
        .board7SD(board7SD)
    );

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [8:0] items, input logic [5:0] coins,
                         input logic cancel, input logic disp);
        {C3, C2, C1, B3, B2, B1, A3, A2, A1} = items;
        {five, dollar, fifty, quarter, dime, nickel} = coins;
        cancelReset = cancel;
        coinsDisp   = disp;
    endtask

    // Hold the buttons for 'hold' edges, release for 3 edges, end on a negedge
    task automatic press(input logic [8:0] items, input logic [5:0] coins,
                         input logic cancel, input logic disp, input int hold);
        @(negedge clk);
        drive(items, coins, cancel, disp);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        drive(9'd0, 6'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic coin(input logic [5:0] c);
        press(9'd0, c, 1'b0, 1'b0, 3);
    endtask

    task automatic item(input logic [8:0] m);
        press(m, 6'd0, 1'b0, 1'b0, 3);
    endtask

    task automatic do_cancel();
        press(9'd0, 6'd0, 1'b1, 1'b0, 3);
    endtask

    task automatic do_disp();
        press(9'd0, 6'd0, 1'b0, 1'b1, 3);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(9'd0, 6'd0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL reset_board: got %h expected %h", board7SD, 32'h0000_0000); end
        vec_count++; if (g !== 9'h000) begin err_count++; $display("FAIL reset_gled: got %h expected %h", g, 9'h000); end
        vec_count++; if (r !== 9'h000) begin err_count++; $display("FAIL reset_rled: got %h expected %h", r, 9'h000); end
    endtask

    task automatic test_select_pending();
        item(M_C3);
        vec_count++; if (board7SD !== 32'h0300_0000) begin err_count++; $display("FAIL sel_c3_board: got %h expected %h", board7SD, 32'h0300_0000); end
        vec_count++; if (g !== 9'h000) begin err_count++; $display("FAIL sel_c3_gled: got %h expected %h", g, 9'h000); end
    endtask

    task automatic test_autovend();
        coin(K_DOLLAR);
        vec_count++; if (board7SD !== 32'h0300_0100) begin err_count++; $display("FAIL autovend_d1_board: got %h expected %h", board7SD, 32'h0300_0100); end
        vec_count++; if (g !== 9'h001) begin err_count++; $display("FAIL autovend_d1_gled: got %h expected %h", g, 9'h001); end
        coin(K_DOLLAR);
        vec_count++; if (board7SD !== 32'h0300_0200) begin err_count++; $display("FAIL autovend_d2_board: got %h expected %h", board7SD, 32'h0300_0200); end
        vec_count++; if (g !== 9'h01F) begin err_count++; $display("FAIL autovend_d2_gled: got %h expected %h", g, 9'h01F); end
        coin(K_DOLLAR);
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL autovend_d3_board: got %h expected %h", board7SD, 32'h0000_0000); end
        vec_count++; if (g !== 9'h000) begin err_count++; $display("FAIL autovend_d3_gled: got %h expected %h", g, 9'h000); end
        vec_count++; if (r !== 9'h000) begin err_count++; $display("FAIL autovend_d3_rled: got %h expected %h", r, 9'h000); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL autovend_change: got %h expected %h", board7SD, 32'h0000_0000); end
        do_disp();
    endtask

    task automatic test_vend_change();
        coin(K_DOLLAR);
        coin(K_DOLLAR);
        coin(K_QUARTER);
        vec_count++; if (board7SD !== 32'h0000_0225) begin err_count++; $display("FAIL credit225_board: got %h expected %h", board7SD, 32'h0000_0225); end
        vec_count++; if (g !== 9'h03F) begin err_count++; $display("FAIL credit225_gled: got %h expected %h", g, 9'h03F); end
        item(M_A1);
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL vend_a1_board: got %h expected %h", board7SD, 32'h0000_0000); end
        vec_count++; if (g !== 9'h000) begin err_count++; $display("FAIL vend_a1_gled: got %h expected %h", g, 9'h000); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0125) begin err_count++; $display("FAIL view_change125: got %h expected %h", board7SD, 32'h0000_0125); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL view_credit0: got %h expected %h", board7SD, 32'h0000_0000); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL change_cleared: got %h expected %h", board7SD, 32'h0000_0000); end
        do_disp();
    endtask

    task automatic test_cancel_refund();
        coin(K_FIVE);
        vec_count++; if (board7SD !== 32'h0000_0500) begin err_count++; $display("FAIL five_board: got %h expected %h", board7SD, 32'h0000_0500); end
        vec_count++; if (g !== 9'h1FF) begin err_count++; $display("FAIL five_gled: got %h expected %h", g, 9'h1FF); end
        do_cancel();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL cancel_board: got %h expected %h", board7SD, 32'h0000_0000); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0500) begin err_count++; $display("FAIL cancel_change: got %h expected %h", board7SD, 32'h0000_0500); end
        do_disp();
    endtask

    task automatic test_credit_max();
        repeat (4) coin(K_FIVE);
        vec_count++; if (board7SD !== 32'h0000_2000) begin err_count++; $display("FAIL credit2000_board: got %h expected %h", board7SD, 32'h0000_2000); end
        coin(K_DOLLAR);
        vec_count++; if (board7SD !== 32'h0000_2000) begin err_count++; $display("FAIL over_limit_board: got %h expected %h", board7SD, 32'h0000_2000); end
        vec_count++; if (g !== 9'h1FF) begin err_count++; $display("FAIL over_limit_gled: got %h expected %h", g, 9'h1FF); end
        do_cancel();
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_2100) begin err_count++; $display("FAIL over_limit_change: got %h expected %h", board7SD, 32'h0000_2100); end
        do_disp();
    endtask

    task automatic test_sold_out();
        // A1 has already been sold once; four more empty it
        repeat (4) begin
            coin(K_DOLLAR);
            item(M_A1);
        end
        vec_count++; if (r !== 9'h001) begin err_count++; $display("FAIL soldout_rled: got %h expected %h", r, 9'h001); end
        vec_count++; if (g !== 9'h000) begin err_count++; $display("FAIL soldout_gled: got %h expected %h", g, 9'h000); end
        coin(K_DOLLAR);
        vec_count++; if (g !== 9'h000) begin err_count++; $display("FAIL soldout_credit_gled: got %h expected %h", g, 9'h000); end
        item(M_A1);
        vec_count++; if (board7SD !== 32'h0000_0100) begin err_count++; $display("FAIL soldout_ignored: got %h expected %h", board7SD, 32'h0000_0100); end
        do_cancel();
        do_disp();
        do_disp();
    endtask

    task automatic test_coin_priority();
        coin(K_DIME | K_DOLLAR);
        vec_count++; if (board7SD !== 32'h0000_0100) begin err_count++; $display("FAIL coin_prio_a: got %h expected %h", board7SD, 32'h0000_0100); end
        coin(K_NICKEL | K_QUARTER);
        vec_count++; if (board7SD !== 32'h0000_0125) begin err_count++; $display("FAIL coin_prio_b: got %h expected %h", board7SD, 32'h0000_0125); end
        do_cancel();
        do_disp();
        do_disp();
    endtask

    task automatic test_item_priority();
        item(M_A2 | M_B1);
        vec_count++; if (board7SD !== 32'h0125_0000) begin err_count++; $display("FAIL item_prio: got %h expected %h", board7SD, 32'h0125_0000); end
        do_cancel();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL item_prio_cancel: got %h expected %h", board7SD, 32'h0000_0000); end
    endtask

    task automatic test_cancel_priority();
        coin(K_QUARTER);
        vec_count++; if (board7SD !== 32'h0000_0025) begin err_count++; $display("FAIL cprio_credit: got %h expected %h", board7SD, 32'h0000_0025); end
        press(9'd0, K_DIME, 1'b1, 1'b0, 3);
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL cprio_board: got %h expected %h", board7SD, 32'h0000_0000); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0025) begin err_count++; $display("FAIL cprio_change: got %h expected %h", board7SD, 32'h0000_0025); end
        do_disp();
    endtask

    task automatic test_back_to_back();
        press(9'd0, K_DIME, 1'b0, 1'b0, 10);
        vec_count++; if (board7SD !== 32'h0000_0010) begin err_count++; $display("FAIL held_once: got %h expected %h", board7SD, 32'h0000_0010); end
        coin(K_DIME);
        vec_count++; if (board7SD !== 32'h0000_0020) begin err_count++; $display("FAIL retrigger: got %h expected %h", board7SD, 32'h0000_0020); end
        do_cancel();
        do_disp();
        do_disp();
    endtask

    task automatic test_reset_mid();
        coin(K_QUARTER);
        do_cancel();
        item(M_C2);
        coin(K_DOLLAR);
        vec_count++; if (board7SD !== 32'h0275_0100) begin err_count++; $display("FAIL mid_board: got %h expected %h", board7SD, 32'h0275_0100); end
        apply_reset();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL mid_reset_board: got %h expected %h", board7SD, 32'h0000_0000); end
        vec_count++; if (r !== 9'h000) begin err_count++; $display("FAIL mid_reset_rled: got %h expected %h", r, 9'h000); end
        do_disp();
        vec_count++; if (board7SD !== 32'h0000_0000) begin err_count++; $display("FAIL mid_reset_change: got %h expected %h", board7SD, 32'h0000_0000); end
        do_disp();
        coin(K_DOLLAR);
        vec_count++; if (g !== 9'h001) begin err_count++; $display("FAIL mid_reset_restock: got %h expected %h", g, 9'h001); end
    endtask

    initial begin
        test_reset();
        test_select_pending();
        test_autovend();
        test_vend_change();
        test_cancel_refund();
        test_credit_max();
        test_sold_out();
        test_coin_priority();
        test_item_priority();
        test_cancel_priority();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
`default_nettype wire
